// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, select codes and sequencer state encoding
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  // ALU operation select codes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_accum_ctrl.sv
// rtl/alu_accum_ctrl.sv - accumulator sequencer feeding an external combinational ALU
module alu_accum_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_sel,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_carry,
  output logic             res_zero,
  output logic [WIDTH-1:0] acc_q
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] res_y_q, res_y_d;
  logic             res_carry_q, res_carry_d;
  logic             res_zero_q, res_zero_d;

  // Handshake outputs are decoded from state alone so ready never loops back through valid
  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_HOLD);

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_y     = res_y_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;

  // Next-state and datapath: accept in IDLE, capture ALU result in EXEC, present in HOLD
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_y_d     = res_y_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            acc_d       = cmd_data;
            res_y_d     = cmd_data;
            res_carry_d = 1'b0;
            res_zero_d  = (cmd_data == '0);
            state_d     = ST_HOLD;
          end else begin
            // A always comes from the accumulator; the ALU sees these on the next cycle
            alu_a_d   = acc_q;
            alu_b_d   = cmd_data;
            alu_sel_d = cmd_sel;
            state_d   = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        acc_d       = alu_y;
        res_y_d     = alu_y;
        res_carry_d = alu_c_out;
        res_zero_d  = (alu_y == '0);
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation or pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_ADD;
      res_y_q     <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_y_q     <= res_y_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_accum_ctrl.sv
// tb/tb_alu_accum_ctrl.sv - self-checking bench for alu_accum_ctrl with a behavioural ALU beside it
module tb_alu_accum_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_sel;
  logic [3:0] cmd_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_y;
  logic       alu_c_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_y;
  logic       res_carry;
  logic       res_zero;
  logic [3:0] acc_q;

  int tests = 0;
  int fails = 0;
  logic [3:0] model_acc;

  always #5 clk = ~clk;

  alu_accum_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_carry(res_carry), .res_zero(res_zero),
    .acc_q(acc_q)
  );

  // ALU behaviour in integer arithmetic: returns {carry, y}
  function automatic logic [4:0] ref_alu(input logic [2:0] sel, input int a, input int b);
    int y;
    int c;
    c = 0;
    case (sel)
      OP_ADD:  begin y = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      OP_SUB:  begin y = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOTA: y = 15 - a;
      OP_SHL:  begin y = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
      default: begin y = a / 2; c = a % 2; end
    endcase
    return {1'(c), 4'(y)};
  endfunction

  logic [4:0] alu_r;
  always_comb begin
    alu_r     = ref_alu(alu_sel, int'(alu_a), int'(alu_b));
    alu_y     = alu_r[3:0];
    alu_c_out = alu_r[4];
  end

  // One full command: accept, measure latency, check result, optional backpressure, handshake
  task automatic send(input logic ld, input logic [2:0] sel, input logic [3:0] data,
                      input int hold, input logic keep_valid, input string nm);
    logic [4:0] r;
    logic [3:0] ey;
    logic       ec;
    int         lat;
    if (ld) begin
      ey = data;
      ec = 1'b0;
    end else begin
      r  = ref_alu(sel, int'(model_acc), int'(data));
      ey = r[3:0];
      ec = r[4];
    end
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL %s cmd_ready_idle got %b want 1", nm, cmd_ready); end
    cmd_valid = 1'b1; cmd_load = ld; cmd_sel = sel; cmd_data = data;
    @(negedge clk);
    if (keep_valid) begin
      cmd_load = 1'b1; cmd_data = 4'hF; cmd_sel = 3'($urandom);
    end else begin
      cmd_valid = 1'b0; cmd_data = 4'($urandom); cmd_sel = 3'($urandom);
    end
    if (!ld) begin
      tests++;
      if (alu_a !== model_acc || alu_b !== data || alu_sel !== sel || cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s alu_regs got a=%h b=%h sel=%h rdy=%b want a=%h b=%h sel=%h rdy=0",
                 nm, alu_a, alu_b, alu_sel, cmd_ready, model_acc, data, sel);
      end
    end
    lat = 1;
    while (res_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != (ld ? 1 : 2)) begin fails++; $display("FAIL %s latency got %0d want %0d", nm, lat, ld ? 1 : 2); end
    tests++;
    if (res_y !== ey || res_carry !== ec || res_zero !== (ey == 4'h0) || acc_q !== ey) begin
      fails++;
      $display("FAIL %s result got y=%h c=%b z=%b acc=%h want y=%h c=%b z=%b acc=%h",
               nm, res_y, res_carry, res_zero, acc_q, ey, ec, ey == 4'h0, ey);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++;
      if (res_valid !== 1'b1 || res_y !== ey || cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold%0d got v=%b y=%h rdy=%b want v=1 y=%h rdy=0", nm, i, res_valid, res_y, cmd_ready, ey);
      end
    end
    res_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || acc_q !== ey) begin
      fails++;
      $display("FAIL %s release got v=%b rdy=%b acc=%h want v=0 rdy=1 acc=%h", nm, res_valid, cmd_ready, acc_q, ey);
    end
    model_acc = ey;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_acc = 4'h0;
    tests++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || acc_q !== 4'h0 || res_y !== 4'h0 ||
        res_carry !== 1'b0 || res_zero !== 1'b1 || alu_a !== 4'h0 || alu_b !== 4'h0 || alu_sel !== 3'b000) begin
      fails++;
      $display("FAIL reset_state got rdy=%b v=%b acc=%h y=%h c=%b z=%b a=%h b=%h sel=%h want 1 0 0 0 0 1 0 0 0",
               cmd_ready, res_valid, acc_q, res_y, res_carry, res_zero, alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_load_add();
    send(1'b1, OP_ADD, 4'b0011, 0, 1'b0, "load_0011");
    send(1'b0, OP_ADD, 4'b0101, 0, 1'b0, "add_0101");
    tests++;
    if (acc_q !== 4'b1000) begin fails++; $display("FAIL load_add_acc got %h want 8", acc_q); end
  endtask

  task automatic test_add_overflow();
    send(1'b1, OP_ADD, 4'b1100, 0, 1'b0, "load_1100");
    send(1'b0, OP_ADD, 4'b0101, 0, 1'b0, "add_ovf");
    tests++;
    if (acc_q !== 4'b0001) begin fails++; $display("FAIL add_ovf_acc got %h want 1", acc_q); end
  endtask

  task automatic test_sub_zero_not();
    send(1'b1, OP_ADD, 4'b0110, 0, 1'b0, "load_0110");
    send(1'b0, OP_SUB, 4'b0110, 0, 1'b0, "sub_zero");
    send(1'b0, OP_NOTA, 4'b1010, 0, 1'b0, "not_a");
    tests++;
    if (acc_q !== 4'b1111) begin fails++; $display("FAIL not_acc got %h want f", acc_q); end
  endtask

  task automatic test_backpressure();
    send(1'b0, OP_XOR, 4'b0101, 5, 1'b0, "backpressure");
    send(1'b1, OP_ADD, 4'b0000, 3, 1'b0, "load_zero_bp");
  endtask

  task automatic test_reset_mid_op();
    send(1'b1, OP_ADD, 4'b0111, 0, 1'b0, "load_0111");
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = OP_ADD; cmd_data = 4'b0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_acc = 4'h0;
    tests++;
    if (acc_q !== 4'h0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_op got acc=%h v=%b rdy=%b want acc=0 v=0 rdy=1", acc_q, res_valid, cmd_ready);
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_no_result got v=%b want 0", res_valid); end
    end
  endtask

  task automatic test_shift_chain();
    send(1'b1, OP_ADD, 4'b0001, 0, 1'b0, "load_0001");
    send(1'b0, OP_SHL, 4'b0010, 2, 1'b1, "shl_1");
    tests++;
    if (acc_q !== 4'b0010) begin fails++; $display("FAIL shl1_acc got %h want 2", acc_q); end
    send(1'b0, OP_SHL, 4'b0010, 2, 1'b1, "shl_2");
    tests++;
    if (acc_q !== 4'b0100) begin fails++; $display("FAIL shl2_acc got %h want 4", acc_q); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      send(($urandom_range(0, 4) == 0), 3'($urandom), 4'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_sel = 3'b000;
    cmd_data = 4'h0; res_ready = 1'b0; model_acc = 4'h0;
    @(negedge clk);
    test_reset();
    test_load_add();
    test_add_overflow();
    test_sub_zero_not();
    test_backpressure();
    test_reset_mid_op();
    test_shift_chain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
